instruction_cache: RTL

Direct-mapped, read-only instruction cache between the CPU fetch stage and the block-based instruction memory.
- Serves 32-bit instructions to the IF stage on a hit in the same cycle.
- On a miss, stalls the CPU and fetches a 128-bit, 4-word block from instruction memory using a READ/BUSYWAIT handshake.

---
 rtl/instruction_cache_if.sv | 35 +++
 rtl/instruction_cache.sv | 122 ++++++++++++
 2 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache attaches through the slave modport. The CPU and the memory model
// drive the other side through the master modport.
interface instruction_cache_if;
  logic         CPU_READ;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_BLOCK_ADDRESS;
  logic [127:0] MEM_READ_INST;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  CPU_READ,
    input  PC,
    input  MEM_READ_INST,
    input  MEM_BUSYWAIT,
    output INSTRUCTION,
    output BUSYWAIT,
    output MEM_READ,
    output MEM_BLOCK_ADDRESS
  );

  modport master (
    output CPU_READ,
    output PC,
    output MEM_READ_INST,
    output MEM_BUSYWAIT,
    input  INSTRUCTION,
    input  BUSYWAIT,
    input  MEM_READ,
    input  MEM_BLOCK_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 128-bit (4-word) lines.
// A hit returns the word in the same cycle. A miss stalls the CPU and
// refills the line from block memory over a READ/BUSYWAIT handshake.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  instruction_cache_if.slave bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  state_t                state_r;
  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [127:0]          data_r [LINES];
  logic                  mem_read_r;
  logic [27:0]           block_addr_r;

  logic [1:0]            offset_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] fill_index_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic [127:0]          line_s;
  logic                  hit_s;
  logic                  busywait_s;
  logic [31:0]           instruction_s;
  logic                  unused_pc_s;

  // The byte offset within a word is irrelevant for word-aligned fetches.
  assign unused_pc_s  = ^bus.PC[1:0];

  assign offset_s     = bus.PC[3:2];
  assign index_s      = bus.PC[3+INDEX_BITS:4];
  assign tag_s        = bus.PC[31:4+INDEX_BITS];

  // The refill uses the block address latched at the miss. A PC that moves
  // during the stall cannot redirect the write.
  assign fill_index_s = block_addr_r[INDEX_BITS-1:0];
  assign fill_tag_s   = block_addr_r[27:INDEX_BITS];

  // Lookup: hit detection, word select and CPU stall.
  always_comb begin
    line_s        = data_r[index_s];
    hit_s         = bus.CPU_READ & valid_r[index_s] & (tag_r[index_s] == tag_s);
    instruction_s = line_s[31:0];
    case (offset_s)
      2'd0:    instruction_s = line_s[31:0];
      2'd1:    instruction_s = line_s[63:32];
      2'd2:    instruction_s = line_s[95:64];
      2'd3:    instruction_s = line_s[127:96];
      default: instruction_s = line_s[31:0];
    endcase
    if (RESET) begin
      busywait_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      busywait_s = bus.CPU_READ & ~hit_s;
    end else begin
      busywait_s = 1'b1;
    end
  end

  // Refill FSM, including the memory request, the latched block address and the line write.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      valid_r      <= '0;
      mem_read_r   <= 1'b0;
      block_addr_r <= bus.PC[31:4];
    end else begin
      case (state_r)
        ST_IDLE: begin
          block_addr_r <= bus.PC[31:4];
          if (bus.CPU_READ & ~hit_s) begin
            state_r    <= ST_MEM_READ;
            mem_read_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            mem_read_r <= 1'b0;
          end
        end
        ST_MEM_READ: begin
          // Entry into this state already used one edge. The earliest exit
          // is therefore one full cycle later.
          if (!bus.MEM_BUSYWAIT) begin
            state_r    <= ST_UPDATE;
            mem_read_r <= 1'b0;
          end else begin
            state_r    <= ST_MEM_READ;
            mem_read_r <= 1'b1;
          end
        end
        ST_UPDATE: begin
          data_r[fill_index_s]  <= bus.MEM_READ_INST;
          tag_r[fill_index_s]   <= fill_tag_s;
          valid_r[fill_index_s] <= 1'b1;
          state_r               <= ST_IDLE;
          mem_read_r            <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_read_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INSTRUCTION       = instruction_s;
  assign bus.BUSYWAIT          = busywait_s;
  assign bus.MEM_READ          = mem_read_r;
  assign bus.MEM_BLOCK_ADDRESS = block_addr_r;

endmodule
